// File: rtl/median_sort_ctrl_pkg.sv
// Shared types and constants for the sequential median-sort controller.
package median_sort_pkg;

    localparam int DATA_SIZE_DEF = 8;
    localparam int WINDOW_DEF    = 9;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Compare cycles of the full odd-even transposition schedule:
    // WINDOW passes of (WINDOW-1)/2 compares each.
    function automatic int sort_cycles(input int window);
        return window * (window - 1) / 2;
    endfunction

endpackage

// File: rtl/median_sort_ctrl_if.sv
// Sample-in / result-out handshake bundle of the median-sort controller.
// master = stream/downstream side, slave = controller side.
interface median_sort_ctrl_if
    import median_sort_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_median;
    logic [DATA_SIZE-1:0] out_max;
    logic [DATA_SIZE-1:0] out_min;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_median, out_max, out_min
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_median, out_max, out_min
    );
endinterface

// File: rtl/median_sort_ctrl_median_sort.sv
// Single compare-exchange cell: larger value on dataOut0, smaller on
// dataOut1. Equal values pass straight through (never swap).
module medianSort #(
    parameter int DATA_SIZE = 8
) (
    input  logic [DATA_SIZE-1:0] dataIn0,
    input  logic [DATA_SIZE-1:0] dataIn1,
    output logic [DATA_SIZE-1:0] dataOut0,
    output logic [DATA_SIZE-1:0] dataOut1
);
    // Unsigned compare; swap only when the lower slot holds the strictly larger value.
    always_comb begin
        dataOut0 = dataIn0;
        dataOut1 = dataIn1;
        if (dataIn1 > dataIn0) begin
            dataOut0 = dataIn1;
            dataOut1 = dataIn0;
        end
    end
endmodule

// File: rtl/median_sort_ctrl.sv
// Sequential median filter controller: loads WINDOW samples, sorts them
// descending in place with one shared compare-exchange cell (odd-even
// transposition), then presents median/max/min until accepted.
// Optional build macro MEDIAN_SORT_EARLY_EXIT_EN: stop sorting after an
// even+odd pass pair that changed nothing.
module median_sort_ctrl
    import median_sort_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int WINDOW    = WINDOW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    median_sort_ctrl_if.slave   bus,
    output logic                busy
);
    localparam int IDX_W  = $clog2(WINDOW);
    localparam int PASS_W = $clog2(WINDOW + 1);

    localparam logic [IDX_W-1:0]  WIN_LAST  = IDX_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]  EVEN_LAST = IDX_W'(WINDOW - 3);
    localparam logic [IDX_W-1:0]  ODD_LAST  = IDX_W'(WINDOW - 2);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(WINDOW - 1);

    generate
        if ((WINDOW % 2) == 0 || WINDOW < 3 || WINDOW > 31) begin : g_bad_window
            $error("median_sort_ctrl: WINDOW must be odd and within 3..31");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_wr_idx;
    logic [IDX_W-1:0]     r_pair_idx;
    logic [PASS_W-1:0]    r_pass;
    logic [DATA_SIZE-1:0] r_win      [WINDOW];
    logic [DATA_SIZE-1:0] w_win_next [WINDOW];

    logic                 w_in_fire;
    logic                 w_pass_end;
    logic                 w_sort_done;
    logic [IDX_W-1:0]     w_pair_idx_p1;
    logic [DATA_SIZE-1:0] w_cmp_a;
    logic [DATA_SIZE-1:0] w_cmp_b;
    logic [DATA_SIZE-1:0] w_cmp_hi;
    logic [DATA_SIZE-1:0] w_cmp_lo;

    // Only LOAD advertises ready, so a handshake is in_valid while loading.
    assign w_in_fire     = bus.in_valid && (r_state == LOAD);
    assign w_pair_idx_p1 = r_pair_idx + IDX_W'(1);

    // Pair mux feeding the shared compare-exchange cell.
    assign w_cmp_a = r_win[r_pair_idx];
    assign w_cmp_b = r_win[w_pair_idx_p1];

    medianSort #(
        .DATA_SIZE (DATA_SIZE)
    ) u_median_sort (
        .dataIn0  (w_cmp_a),
        .dataIn1  (w_cmp_b),
        .dataOut0 (w_cmp_hi),
        .dataOut1 (w_cmp_lo)
    );

    // Even passes end at pair WINDOW-3, odd passes at pair WINDOW-2.
    assign w_pass_end = r_pass[0] ? (r_pair_idx == ODD_LAST) : (r_pair_idx == EVEN_LAST);

`ifdef MEDIAN_SORT_EARLY_EXIT_EN
    logic r_swap;
    logic w_swap;

    assign w_swap = (w_cmp_hi != w_cmp_a);

    // Swap flag accumulates over an even+odd pass pair; cleared before each even pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_swap <= 1'b0;
        end else if (r_state != SORT) begin
            r_swap <= 1'b0;
        end else if (w_pass_end && r_pass[0]) begin
            r_swap <= 1'b0;
        end else begin
            r_swap <= r_swap | w_swap;
        end
    end

    assign w_sort_done = w_pass_end &&
                         ((r_pass == PASS_LAST) || (r_pass[0] && !(r_swap || w_swap)));
`else
    assign w_sort_done = w_pass_end && (r_pass == PASS_LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/status outputs; ready is masked while reset is held.
    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (r_state)
            LOAD: begin
                bus.in_ready = !rst;
                if (bus.in_valid && (r_wr_idx == WIN_LAST)) begin
                    w_state_next = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (w_sort_done) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    // Write index, pair index and pass counter; LOAD keeps the sort counters parked at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx   <= '0;
            r_pair_idx <= '0;
            r_pass     <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_pair_idx <= '0;
                    r_pass     <= '0;
                    if (w_in_fire) begin
                        r_wr_idx <= (r_wr_idx == WIN_LAST) ? '0 : r_wr_idx + IDX_W'(1);
                    end
                end
                SORT: begin
                    if (w_pass_end) begin
                        r_pass     <= r_pass + PASS_W'(1);
                        r_pair_idx <= r_pass[0] ? IDX_W'(0) : IDX_W'(1);
                    end else begin
                        r_pair_idx <= r_pair_idx + IDX_W'(2);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-slot next value: sample write in LOAD, compare write-back in SORT.
    generate
        for (genvar gi = 0; gi < WINDOW; gi++) begin : g_win
            assign w_win_next[gi] =
                (w_in_fire && (r_wr_idx == IDX_W'(gi)))               ? bus.in_data :
                ((r_state == SORT) && (r_pair_idx == IDX_W'(gi)))    ? w_cmp_hi    :
                ((r_state == SORT) && (w_pair_idx_p1 == IDX_W'(gi))) ? w_cmp_lo    :
                                                                        r_win[gi];
        end
    endgenerate

    // Window register array; clears to zero so results read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WINDOW; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_win <= w_win_next;
        end
    end

    assign bus.out_max    = r_win[0];
    assign bus.out_median = r_win[WINDOW / 2];
    assign bus.out_min    = r_win[WINDOW - 1];

endmodule

// File: tb/tb_median_sort_ctrl.sv
// Scoreboard bench for median_sort_ctrl (WINDOW=9, DATA_SIZE=8).
// Build with MEDIAN_SORT_EARLY_EXIT_EN to exercise the early-exit latencies.
module tb_median_sort_ctrl;
    import median_sort_pkg::*;

    localparam int DW  = 8;
    localparam int WIN = 9;
    localparam int N   = sort_cycles(WIN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    median_sort_ctrl_if #(.DATA_SIZE(DW)) bus ();

    median_sort_ctrl #(
        .DATA_SIZE (DW),
        .WINDOW    (WIN)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        int    med;
        int    mx;
        int    mn;
        int    lat_min;
        int    lat_max;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    bit   seen       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: latency on first out_valid, values on the output handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                if (bus.out_ready) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got result median=%0d, required no pending result",
                             bus.out_median);
                end
            end else begin
                if (!seen) begin
                    int lat;
                    seen = 1'b1;
                    lat  = cyc - accept_cyc;
                    n_cmp++;
                    if (lat < sb[0].lat_min || lat > sb[0].lat_max) begin
                        n_bad++;
                        $display("FAIL %s_latency: got %0d, required %0d..%0d",
                                 sb[0].name, lat, sb[0].lat_min, sb[0].lat_max);
                    end
                end
                if (bus.out_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    seen = 1'b0;
                    check({e.name, "_median"}, int'(bus.out_median), e.med);
                    check({e.name, "_max"},    int'(bus.out_max),    e.mx);
                    check({e.name, "_min"},    int'(bus.out_min),    e.mn);
                    $display("result %s: median=%0d max=%0d min=%0d", e.name,
                             bus.out_median, bus.out_max, bus.out_min);
                end
            end
        end
    end

    // Offer one sample (optionally after random idle cycles) until accepted.
    task automatic drive_sample(input logic [7:0] v, input bit gaps);
        int g;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        for (int k = 0; k < g; k++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hFA;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        for (int t = 0; t < 200; t++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hFA;
                return;
            end
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, required 1");
        bus.in_valid = 1'b0;
    endtask

    task automatic load_window(input logic [7:0] v [WIN], input bit gaps, input bit push,
                               input int med, input int mx, input int mn,
                               input int lmin, input int lmax, input string name);
        exp_t e;
        for (int i = 0; i < WIN; i++) begin
            drive_sample(v[i], gaps);
        end
        accept_cyc = cyc;
        if (push) begin
            e.med = med; e.mx = mx; e.mn = mn;
            e.lat_min = lmin; e.lat_max = lmax; e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 300; t++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got %0d pending results, required 0", name, sb.size());
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w [WIN];
        int desc_lmin, desc_lmax, asc_lmin;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready",   int'(bus.in_ready),   0);
        check("rst_out_valid",  int'(bus.out_valid),  0);
        check("rst_busy",       int'(busy),           0);
        check("rst_out_median", int'(bus.out_median), 0);
        check("rst_out_max",    int'(bus.out_max),    0);
        check("rst_out_min",    int'(bus.out_min),    0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        check("post_rst_busy",     int'(busy),         0);

        // Basic window.
        w = '{5, 1, 9, 3, 7, 2, 8, 4, 6};
        load_window(w, 1'b0, 1'b1, 5, 9, 1, N, N, "basic");
        wait_drain("basic");

        // Duplicates and extremes.
        w = '{255, 0, 255, 0, 128, 128, 0, 255, 128};
        load_window(w, 1'b0, 1'b1, 128, 255, 0, N, N, "dup_ext");
        wait_drain("dup_ext");

        // All equal values.
        w = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        load_window(w, 1'b0, 1'b1, 7, 7, 7, N, N, "all_equal");
        wait_drain("all_equal");

        // Backpressure with random in_valid gaps; invalid cycles carry 0xFA.
        bus.out_ready = 1'b0;
        w = '{10, 200, 30, 40, 50, 60, 70, 80, 90};
        load_window(w, 1'b1, 1'b1, 60, 200, 10, N, N, "backpressure");
        for (int t = 0; t < 100; t++) begin
            if (bus.out_valid) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFA;
        for (int h = 0; h < 10; h++) begin
            check("hold_out_valid", int'(bus.out_valid),  1);
            check("hold_in_ready",  int'(bus.in_ready),   0);
            check("hold_median",    int'(bus.out_median), 60);
            check("hold_max",       int'(bus.out_max),    200);
            check("hold_min",       int'(bus.out_min),    10);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_in_ready",  int'(bus.in_ready),  1);
        check("post_hs_out_valid", int'(bus.out_valid), 0);
        wait_drain("backpressure");

        // Reset mid-LOAD discards the partial window.
        for (int i = 0; i < 4; i++) drive_sample(8'd250, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        w = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_window(w, 1'b0, 1'b1, 5, 9, 1, N, N, "after_load_rst");
        wait_drain("after_load_rst");

        // Reset mid-SORT at compare cycle 17.
        w = '{200, 3, 3, 3, 3, 3, 3, 3, 250};
        load_window(w, 1'b0, 1'b0, 0, 0, 0, 0, 0, "aborted");
        repeat (16) @(negedge clk);
        check("mid_sort_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("sort_rst_busy",      int'(busy),          0);
        check("sort_rst_out_valid", int'(bus.out_valid), 0);
        check("sort_rst_in_ready",  int'(bus.in_ready),  1);
        w = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        load_window(w, 1'b0, 1'b1, 5, 9, 1, N, N, "after_sort_rst");
        wait_drain("after_sort_rst");

        // Presorted / reverse-sorted windows (latency depends on early exit).
`ifdef MEDIAN_SORT_EARLY_EXIT_EN
        desc_lmin = WIN - 1; desc_lmax = WIN - 1; asc_lmin = WIN - 1;
`else
        desc_lmin = N; desc_lmax = N; asc_lmin = N;
`endif
        w = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        load_window(w, 1'b0, 1'b1, 5, 9, 1, desc_lmin, desc_lmax, "descending");
        wait_drain("descending");
        w = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_window(w, 1'b0, 1'b1, 5, 9, 1, asc_lmin, N, "ascending");
        wait_drain("ascending");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/median_sort_ctrl.md
# median_sort_ctrl

Sequential median-filter controller that time-multiplexes one `medianSort` compare-exchange unit across a window of `WINDOW` samples. It loads a window through a valid/ready input, sorts the window in place with an odd-even transposition schedule, and presents median, maximum and minimum through a valid/ready output. It sits between the sample stream and downstream filter logic, trading latency for a single comparator.

## Interface
- `DATA_SIZE`, 8, sample width in bits.
- `WINDOW`, 9, samples per window. Must be odd, 3..31; any other value is an elaboration error.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `in_data`  in  DATA_SIZE  unsigned sample.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_median`  out  DATA_SIZE  sorted element at index WINDOW/2.
- `out_max`  out  DATA_SIZE  sorted element at index 0.
- `out_min`  out  DATA_SIZE  sorted element at index WINDOW-1.
- `busy`  out  1  high in SORT state.

## Operation
- Register array `win[0..WINDOW-1]` is sorted descending, index 0 largest. Comparison is unsigned.
- States:
  - LOAD: `in_ready`=1. Each handshake writes `win[wr_idx]` and increments `wr_idx`. Acceptance of sample WINDOW-1 moves to SORT and clears `wr_idx`.
  - SORT: one compare-exchange per cycle on pair (`win[i]`, `win[i+1]`) through the `medianSort` instance. `dataOut0` is written to `win[i]` and `dataOut1` to `win[i+1]`.
    - Even pass: i = 0,2,..,WINDOW-3.
    - Odd pass: i = 1,3,..,WINDOW-2.
    - Each pass is (WINDOW-1)/2 cycles. Passes alternate even, odd, even, and so on.
    - Fixed schedule: WINDOW passes. After the last compare, go to OUT.
  - OUT: `out_valid`=1. Outputs are driven from `win` and held stable until `out_ready`. On the handshake, go to LOAD.
- Equal values never swap.
- `in_ready`=0 in SORT and OUT. Input and output never overlap, so no simultaneous-event priority is needed.
- Width rules:
  - Index and counters are `$clog2(WINDOW)` bits.
  - Pass counter is `$clog2(WINDOW+1)` bits.
  - No arithmetic on data; only compare and move.
- Reset values:
  - `in_ready`=0 during reset, then 1 from the first cycle after reset (LOAD).
  - `out_valid`=0, `busy`=0.
  - `out_median`/`out_max`/`out_min`=0, because `win` clears to 0.
  - State is LOAD, all counters 0.
- Reset asserted mid-LOAD, mid-SORT or in OUT discards the partial window and any pending result. No output handshake occurs.

## Timing
- Sample accepted on edge E0 when `in_valid`&`in_ready`.
- If E0 accepts the last sample, compares write back on edges E1..EN, where N = WINDOW*(WINDOW-1)/2 (N=36 for WINDOW=9).
- `out_valid` rises after EN, i.e. N cycles after the final acceptance.
- `in_ready` returns the cycle after the output handshake edge.
- Throughput for WINDOW=9 with always-ready neighbours: 9 + 36 + 1 = 46 cycles per window.
- `busy` is high exactly during the N compare cycles.

## Configuration
- `MEDIAN_SORT_EARLY_EXIT_EN` defined:
  - A swap flag is set whenever a compare changes the pair (`dataOut0` != `win[i]`).
  - The flag is cleared at the start of each even pass.
  - At the end of each odd pass, if the flag is 0, SORT ends immediately and moves to OUT.
  - Latency is variable, minimum 2*(WINDOW-1)/2 cycles (8 for WINDOW=9), maximum N.
- Not defined: fixed N-cycle schedule; swap-flag logic is absent.

## Structure
- Package `median_sort_pkg`:
  - state enum {LOAD, SORT, OUT};
  - default constants for DATA_SIZE and WINDOW;
  - a localparam function computing N from WINDOW.
- One sub-module: a single `medianSort` instance with DATA_SIZE passed through. Its inputs come from a mux on `win[i]` and `win[i+1]`.
- Everything else lives in `median_sort_ctrl`.

## Test plan
- Tests use WINDOW=9, DATA_SIZE=8, fixed schedule unless stated.
1. Basic: load 5,1,9,3,7,2,8,4,6 back-to-back with `out_ready`=1 -> `out_median`=5, `out_max`=9, `out_min`=1, `out_valid` rises exactly 36 cycles after the 9th acceptance.
2. Duplicates and extremes: 255,0,255,0,128,128,0,255,128 -> median 128, max 255, min 0.
3. Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> outputs stable, `in_ready`=0 throughout, `in_ready`=1 the cycle after the handshake. Also toggle `in_valid` randomly during LOAD -> only handshaked samples are stored.
4. Reset mid-SORT: pulse `rst` at compare cycle 17 -> next cycle `busy`=0, `out_valid`=0, `in_ready`=1. A fresh window 9,8,7,6,5,4,3,2,1 then yields median 5.
5. Early exit (`MEDIAN_SORT_EARLY_EXIT_EN` defined): already-descending 9..1 -> `out_valid` 8 cycles after last acceptance, median 5. Ascending 1..9 -> same result, latency at most 36.
